// File: rtl/gpio_chain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : gpio_chain_pkg                                             |
// | Description : Shared definitions for the GPIO serial configuration       |
// |               chain loader: loader state encoding and the default        |
// |               number of configuration bits held by each GPIO block.      |
// | Contents    : c_PAD_CTRL_BITS_DEFAULT - default bits per GPIO block      |
// |               state_t                 - loader sequencing states         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package gpio_chain_pkg;

  // Bits of pad configuration carried by one GPIO control block.
  localparam int c_PAD_CTRL_BITS_DEFAULT = 13;

  // Loader sequencing. SHIFT_LO/SHIFT_HI form the two halves of one
  // chain_clock period; everything else is one-shot bookkeeping.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    CAPTURE  = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    LOAD     = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage : gpio_chain_pkg
`default_nettype wire

// File: rtl/gpio_chain_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gpio_chain_loader                                          |
// | Description : Reloads a serial chain of NUM_IO GPIO control blocks.      |
// |               For every block, highest index first, the configuration    |
// |               word is read from an external word store, then shifted     |
// |               out MSB first with a bit-banged chain clock. After the     |
// |               last word a two-cycle load strobe transfers the shifted    |
// |               contents into the blocks' active registers.                |
// | Ports       : serial_clock - clock, rising edge                          |
// |               resetn       - asynchronous active-low reset               |
// |               start        - single-cycle reload request (IDLE only)     |
// |               busy         - high while a reload is in progress          |
// |               done         - one-cycle pulse after the load strobe       |
// |               cfg_rd_en    - one-cycle read strobe to the word store     |
// |               cfg_rd_idx   - GPIO index being read                       |
// |               cfg_rd_word  - word store data, valid one cycle after      |
// |                              cfg_rd_en                                   |
// |               chain_clock  - shift clock to the chain                    |
// |               chain_data   - serial data to the first chain block        |
// |               chain_load   - load strobe to the chain                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gpio_chain_loader
  import gpio_chain_pkg::*;
#(
  parameter int NUM_IO        = 19,
  parameter int PAD_CTRL_BITS = c_PAD_CTRL_BITS_DEFAULT,
  localparam int IDX_W        = (NUM_IO > 1) ? $clog2(NUM_IO) : 1
) (
  input  logic                     serial_clock,
  input  logic                     resetn,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_rd_en,
  output logic [IDX_W-1:0]         cfg_rd_idx,
  input  logic [PAD_CTRL_BITS-1:0] cfg_rd_word,
  output logic                     chain_clock,
  output logic                     chain_data,
  output logic                     chain_load
);

  localparam int                 c_BIT_W    = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_IO - 1);
  localparam logic [c_BIT_W-1:0] c_MSB_BIT  = c_BIT_W'(PAD_CTRL_BITS - 1);

  state_t                   r_state;
  logic [PAD_CTRL_BITS-1:0] r_hold;      // word currently being shifted out
  logic [c_BIT_W-1:0]       r_bit_cnt;   // bit position now on chain_data
  logic                     r_load_cnt;  // second cycle of the load strobe

  logic [c_BIT_W-1:0]       w_bit_next;

  assign w_bit_next = r_bit_cnt - 1'b1;

  // Every output is a flop set on the transition INTO the state that owns
  // it, so outputs line up with the state and never glitch. cfg_rd_idx
  // doubles as the index counter: it already holds the current index.
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_bit_cnt   <= '0;
      r_load_cnt  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_rd_en   <= 1'b0;
      cfg_rd_idx  <= '0;
      chain_clock <= 1'b0;
      chain_data  <= 1'b0;
      chain_load  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= FETCH;
            busy       <= 1'b1;
            cfg_rd_en  <= 1'b1;
            cfg_rd_idx <= c_LAST_IDX;
          end
        end

        FETCH: begin
          // Word store answers during CAPTURE.
          r_state   <= CAPTURE;
          cfg_rd_en <= 1'b0;
        end

        CAPTURE: begin
          // The MSB goes straight to chain_data so the first SHIFT_LO
          // already presents it.
          r_state     <= SHIFT_LO;
          r_hold      <= cfg_rd_word;
          r_bit_cnt   <= c_MSB_BIT;
          chain_clock <= 1'b0;
          chain_data  <= cfg_rd_word[PAD_CTRL_BITS-1];
        end

        SHIFT_LO: begin
          // Rising chain_clock; chain_data is held from SHIFT_LO.
          r_state     <= SHIFT_HI;
          chain_clock <= 1'b1;
        end

        SHIFT_HI: begin
          chain_clock <= 1'b0;
          if (r_bit_cnt != '0) begin
            r_state    <= SHIFT_LO;
            r_bit_cnt  <= w_bit_next;
            chain_data <= r_hold[w_bit_next];
          end else begin
            chain_data <= 1'b0;
            if (cfg_rd_idx == '0) begin
              r_state    <= LOAD;
              r_load_cnt <= 1'b0;
              chain_load <= 1'b1;
            end else begin
              r_state    <= FETCH;
              cfg_rd_idx <= cfg_rd_idx - 1'b1;
              cfg_rd_en  <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (r_load_cnt) begin
            r_state    <= DONE;
            r_load_cnt <= 1'b0;
            chain_load <= 1'b0;
            done       <= 1'b1;
          end else begin
            r_load_cnt <= 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          r_state     <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          cfg_rd_en   <= 1'b0;
          chain_clock <= 1'b0;
          chain_data  <= 1'b0;
          chain_load  <= 1'b0;
        end
      endcase
    end
  end

endmodule : gpio_chain_loader
`default_nettype wire

// File: tb/tb_gpio_chain_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gpio_chain_loader                                       |
// | Description : Self-checking bench for gpio_chain_loader. Two instances   |
// |               (2-block and 19-block chains) share clock, reset and the   |
// |               word store model; one is selected at a time. Stimulus      |
// |               pushes expected reads, serial bits and chain contents into |
// |               queues; a monitor pops and compares them as the selected   |
// |               DUT presents reads, chain_clock edges, load and done.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gpio_chain_loader;

  localparam int P    = 13;
  localparam int NMAX = 19;

  logic serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  logic         resetn;
  logic         start2, start19;
  logic [P-1:0] cfg_rd_word;

  logic       busy2, done2, rd_en2, clk2, data2, load2;
  logic [0:0] idx2;
  logic       busy19, done19, rd_en19, clk19, data19, load19;
  logic [4:0] idx19;

  gpio_chain_loader #(.NUM_IO(2), .PAD_CTRL_BITS(P)) u_dut2 (
    .serial_clock (serial_clock),
    .resetn       (resetn),
    .start        (start2),
    .busy         (busy2),
    .done         (done2),
    .cfg_rd_en    (rd_en2),
    .cfg_rd_idx   (idx2),
    .cfg_rd_word  (cfg_rd_word),
    .chain_clock  (clk2),
    .chain_data   (data2),
    .chain_load   (load2)
  );

  gpio_chain_loader #(.NUM_IO(19), .PAD_CTRL_BITS(P)) u_dut19 (
    .serial_clock (serial_clock),
    .resetn       (resetn),
    .start        (start19),
    .busy         (busy19),
    .done         (done19),
    .cfg_rd_en    (rd_en19),
    .cfg_rd_idx   (idx19),
    .cfg_rd_word  (cfg_rd_word),
    .chain_clock  (clk19),
    .chain_data   (data19),
    .chain_load   (load19)
  );

  // ---------------- selected-DUT view ----------------
  bit   sel;  // 0: 2-block instance, 1: 19-block instance
  int   nio;
  logic m_busy, m_done, m_rd_en, m_clk, m_data, m_load;
  int   m_idx;

  always_comb begin
    m_busy  = sel ? busy19  : busy2;
    m_done  = sel ? done19  : done2;
    m_rd_en = sel ? rd_en19 : rd_en2;
    m_clk   = sel ? clk19   : clk2;
    m_data  = sel ? data19  : data2;
    m_load  = sel ? load19  : load2;
    m_idx   = sel ? int'(idx19) : int'(idx2);
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int           n;
    logic [P-1:0] w [NMAX];
    longint       start_edge;  // -1: starts two edges after previous done
  } xfer_t;

  xfer_t        xq[$];
  bit           exp_bits[$];
  int           exp_idx[$];
  bit           rx[$];
  logic [P-1:0] mem [NMAX];

  longint cyc = 0;
  int     checks = 0, failures = 0;
  int     n_done = 0, n_loads = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event (edge %0d)", name, cyc);
  endtask

  // Expected behaviour of one reload: indices n-1..0, each word MSB first,
  // and afterwards block k of the chain holds word k.
  task automatic issue(input bit chained);
    xfer_t t;
    t.n = nio;
    for (int i = 0; i < NMAX; i++) t.w[i] = mem[i];
    t.start_edge = chained ? -1 : cyc + 1;
    for (int i = nio - 1; i >= 0; i--) begin
      exp_idx.push_back(i);
      for (int b = P - 1; b >= 0; b--) exp_bits.push_back(mem[i][b]);
    end
    xq.push_back(t);
  endtask

  task automatic drive_start(input logic v);
    if (sel) start19 = v;
    else     start2  = v;
  endtask

  task automatic pulse_start();
    @(negedge serial_clock);
    issue(1'b0);
    drive_start(1'b1);
    @(negedge serial_clock);
    drive_start(1'b0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(negedge serial_clock);
      k++;
    end
    check("done_count", n_done, target);
  endtask

  // ---------------- monitor / word store ----------------
  logic   prev_clk, prev_load, prev_rd_en;
  int     prev_idx;
  int     busy_run, load_run;
  xfer_t  mt;
  logic [P-1:0] mw;
  int     len;
  longint lat;

  always @(posedge serial_clock) begin
    cyc++;
    #1;
    if (!resetn) begin
      xq.delete();
      exp_bits.delete();
      exp_idx.delete();
      rx.delete();
      busy_run    = 0;
      load_run    = 0;
      prev_clk    = 1'b0;
      prev_load   = 1'b0;
      prev_rd_en  = 1'b0;
      prev_idx    = 0;
      cfg_rd_word = P'($urandom);
    end else begin
      // Store returns the addressed word one cycle after the read strobe;
      // at all other times it presents garbage.
      cfg_rd_word = prev_rd_en ? mem[prev_idx] : P'($urandom);

      if (m_rd_en) begin
        if (exp_idx.size() == 0) fail_now("rd_idx_extra");
        else check("rd_idx", m_idx, exp_idx.pop_front());
      end

      if (m_clk && !prev_clk) begin
        rx.push_back(m_data);
        if (exp_bits.size() == 0) fail_now("chain_bit_extra");
        else check("chain_bit", m_data, exp_bits.pop_front());
      end

      if (!m_busy || m_rd_en || prev_rd_en || m_load || m_done)
        check("data_zero_outside_shift", m_data, 0);

      if (m_load) begin
        load_run++;
        check("clk_low_in_load", m_clk, 0);
      end

      if (m_load && !prev_load) begin
        n_loads++;
        if (xq.size() == 0) fail_now("load_extra");
        else begin
          len = rx.size();
          check("chain_bits_before_load", len, xq[0].n * P);
          if (len >= xq[0].n * P) begin
            for (int k = 0; k < xq[0].n; k++) begin
              mw = '0;
              for (int j = 0; j < P; j++) mw = (mw << 1) | P'(rx[len - (k + 1) * P + j]);
              check($sformatf("block%0d_word", k), mw, xq[0].w[k]);
            end
          end
          rx.delete();
        end
      end

      if (m_busy) busy_run++;

      if (m_done) begin
        n_done++;
        if (xq.size() == 0) fail_now("done_extra");
        else begin
          mt  = xq.pop_front();
          lat = longint'(mt.n) * (2 + 2 * P) + 3;
          check("done_latency", cyc - mt.start_edge + 1, lat);
          check("busy_cycles", busy_run, lat);
          check("load_cycles", load_run, 2);
          check("busy_with_done", m_busy, 1);
          if (xq.size() > 0 && xq[0].start_edge < 0) begin
            mt = xq.pop_front();
            mt.start_edge = cyc + 2;
            xq.push_front(mt);
          end
        end
        load_run = 0;
      end

      if (!m_busy) busy_run = 0;

      prev_clk   = m_clk;
      prev_load  = m_load;
      prev_rd_en = m_rd_en;
      prev_idx   = m_idx;
    end
  end

  // ---------------- stimulus ----------------
  int     base;
  int     loads_before;
  longint e_start;

  initial begin
    resetn  = 1'b0;
    start2  = 1'b0;
    start19 = 1'b0;
    sel     = 1'b0;
    nio     = 2;
    for (int i = 0; i < NMAX; i++) mem[i] = '0;
    repeat (3) @(negedge serial_clock);
    check("reset_outputs_n2",  {busy2, done2, rd_en2, idx2, clk2, data2, load2}, 0);
    check("reset_outputs_n19", {busy19, done19, rd_en19, idx19, clk19, data19, load19}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge serial_clock);

    // Directed two-block reload.
    mem[1] = 13'h0155;
    mem[0] = 13'h1ABC;
    pulse_start();
    wait_done(1, 200);

    // start re-pulsed in the middle of shifting must be ignored.
    pulse_start();
    repeat (20) @(negedge serial_clock);
    drive_start(1'b1);
    @(negedge serial_clock);
    drive_start(1'b0);
    wait_done(2, 200);
    repeat (70) @(negedge serial_clock);
    check("single_done_after_repulse", n_done, 2);

    // Random words with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      mem[0] = P'($urandom);
      mem[1] = P'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge serial_clock);
      pulse_start();
      wait_done(3 + r, 200);
    end

    // start held high: three back-to-back reloads.
    base   = n_done;
    mem[0] = P'($urandom);
    mem[1] = P'($urandom);
    @(negedge serial_clock);
    issue(1'b0);
    issue(1'b1);
    issue(1'b1);
    drive_start(1'b1);
    wait_done(base + 2, 400);
    repeat (2) @(negedge serial_clock);
    drive_start(1'b0);
    wait_done(base + 3, 200);
    repeat (70) @(negedge serial_clock);
    check("back_to_back_count", n_done, base + 3);

    // Reset during word 0 bit 5.
    base         = n_done;
    loads_before = n_loads;
    mem[0]       = P'($urandom);
    mem[1]       = P'($urandom);
    @(negedge serial_clock);
    issue(1'b0);
    e_start = cyc + 1;
    drive_start(1'b1);
    @(negedge serial_clock);
    drive_start(1'b0);
    // Word 0 begins at cycle 29; its bit 5 SHIFT_LO is cycle 45 (edge +44).
    while (cyc < e_start + 44) @(negedge serial_clock);
    check("pre_reset_busy", m_busy, 1);
    resetn = 1'b0;
    #1;
    check("abort_outputs_zero", {busy2, done2, rd_en2, idx2, clk2, data2, load2}, 0);
    repeat (3) @(negedge serial_clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge serial_clock);
      check("idle_after_reset", m_busy, 0);
    end
    check("no_load_on_abort", n_loads, loads_before);
    check("no_done_on_abort", n_done, base);
    pulse_start();
    wait_done(base + 1, 200);

    // 19-block chain, word[i] = i, then random words.
    repeat (3) @(negedge serial_clock);
    sel = 1'b1;
    nio = 19;
    for (int i = 0; i < NMAX; i++) mem[i] = P'(i);
    @(negedge serial_clock);
    pulse_start();
    wait_done(base + 2, 700);
    for (int i = 0; i < NMAX; i++) mem[i] = P'($urandom);
    pulse_start();
    wait_done(base + 3, 700);

    repeat (5) @(negedge serial_clock);
    check("scoreboard_drained", xq.size() + exp_bits.size() + exp_idx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_gpio_chain_loader
`default_nettype wire

// File: doc/gpio_chain_loader.md
GPIO_CHAIN_LOADER -- requirements
Module: gpio_chain_loader

Interface
REQ-001 SHALL have parameter NUM_IO, default 19: number of GPIO control blocks in the serial chain.
REQ-002 SHALL have parameter PAD_CTRL_BITS, default 13: configuration bits per GPIO control block.
REQ-003 SHALL have port serial_clock, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle request to reload the whole chain.
REQ-006 SHALL have port busy, output, 1: transfer in progress.
REQ-007 SHALL have port done, output, 1: one-cycle pulse when the load strobe has completed.
REQ-008 SHALL have port cfg_rd_en, output, 1: read strobe to the configuration word store.
REQ-009 SHALL have port cfg_rd_idx, output, clog2(NUM_IO): GPIO index being read.
REQ-010 SHALL have port cfg_rd_word, input, PAD_CTRL_BITS: word returned one cycle after cfg_rd_en.
REQ-011 SHALL have port chain_clock, output, 1: shift clock to the chain, captured by the chain on its rising edge.
REQ-012 SHALL have port chain_data, output, 1: serial data to the first block in the chain.
REQ-013 SHALL have port chain_load, output, 1: load strobe, captured by the chain on its rising edge.

Function
REQ-014 SHALL implement states IDLE, FETCH, CAPTURE, SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-015 SHALL leave IDLE for FETCH only when start=1 is sampled in IDLE, and SHALL ignore start in every other state.
REQ-016 SHALL hold cfg_rd_en=1 for exactly one cycle in FETCH and drive cfg_rd_idx with the current index.
REQ-017 SHALL latch cfg_rd_word into a PAD_CTRL_BITS holding register in CAPTURE.
REQ-018 SHALL send indices in order NUM_IO-1 down to 0, so that the word for index 0 ends nearest the loader.
REQ-019 SHALL send each word MSB first, bit PAD_CTRL_BITS-1 through bit 0.
REQ-020 SHALL, per bit: in SHIFT_LO drive chain_clock=0 and chain_data=current bit; in SHIFT_HI drive chain_clock=1 and hold chain_data; each bit therefore takes 2 cycles.
REQ-021 SHALL, after bit 0, go to FETCH for the next index, or to LOAD if the index just sent was 0.
REQ-022 SHALL hold chain_load=1 with chain_clock=0 for exactly 2 cycles in LOAD, then enter DONE.
REQ-023 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL drive busy=1 in every state other than IDLE, so busy and done are both 1 in DONE.
REQ-025 SHALL drive all chain_* outputs and cfg_rd_en from flops, with no combinational glitches.
REQ-026 SHALL keep bit and index counters wide enough for PAD_CTRL_BITS and NUM_IO, with no wrap-around within a transfer.
REQ-027 Per-word cost SHALL be 2+2*PAD_CTRL_BITS cycles; done SHALL assert NUM_IO*(2+2*PAD_CTRL_BITS)+3 cycles after start is sampled.
REQ-028 SHALL drive chain_data=0 whenever the block is outside SHIFT_LO and SHIFT_HI.

Reset
REQ-029 While resetn=0, SHALL force state=IDLE and busy, done, cfg_rd_en, cfg_rd_idx, chain_clock, chain_data and chain_load to 0, and clear the holding register and counters.
REQ-030 Reset mid-transfer SHALL abort immediately with no chain_load pulse; after release, the block SHALL need a new start.

Structure
REQ-031 A shared package gpio_chain_pkg SHALL hold the state enumeration and the PAD_CTRL_BITS default constant.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 NUM_IO=2, word[1]=13'h0155, word[0]=13'h1ABC, one start pulse -> chain_data on 26 chain_clock rising edges = 13'h0155 MSB first, then 13'h1ABC MSB first; a behavioural 2-block chain model loads 13'h1ABC into block 0 and 13'h0155 into block 1 after the chain_load rising edge.
REQ-034 Same setup -> done asserts exactly 59 cycles after start is sampled; busy=1 for 59 cycles; chain_load=1 for exactly 2 cycles.
REQ-035 start re-pulsed in the middle of SHIFT -> sequence unchanged; exactly one done pulse.
REQ-036 resetn driven low during word 0 bit 5 -> all outputs 0 immediately; no chain_load edge; a new start after release runs a full 59-cycle transfer.
REQ-037 start held high continuously -> back-to-back transfers; each new transfer begins the cycle after IDLE is re-entered.
REQ-038 NUM_IO=19 with word[i]=i -> cfg_rd_idx sequence 18..0; done asserts 19*28+3=535 cycles after start.
